// File: rtl/bht_pkg.sv
// Shared definitions for the saturating-counter branch history table:
// default geometry, counter type and the saturating next-value function.
package bht_pkg;

  localparam int BHT_INDEX_W = 2;
  localparam int BHT_CTR_W   = 2;
  // Widest counter the helper function handles; callers cast in and out.
  localparam int CTR_W_MAX   = 32;

  typedef logic [BHT_CTR_W-1:0] ctr_t;
  typedef logic [CTR_W_MAX-1:0] ctr_wide_t;

  function automatic ctr_wide_t sat_update(input ctr_wide_t ctr,
                                           input logic      taken,
                                           input ctr_wide_t max);
    ctr_wide_t nxt;
    if (taken) begin
      nxt = (ctr == max) ? max : ctr + 32'd1;
    end else begin
      nxt = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// One BHT entry: a CTR_W-bit saturating counter with synchronous load,
// increment and decrement (load has priority, then inc, then dec).
module bht_sat_ctr
  import bht_pkg::*;
#(
  parameter int CTR_W = BHT_CTR_W
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = load_val_i;
    end else if (inc_i) begin
      ctr_d = CTR_W'(sat_update(CTR_W_MAX'(ctr_q), 1'b1, CTR_W_MAX'(CTR_MAX)));
    end else if (dec_i) begin
      ctr_d = CTR_W'(sat_update(CTR_W_MAX'(ctr_q), 1'b0, CTR_W_MAX'(CTR_MAX)));
    end else begin
      ctr_d = ctr_q;
    end
  end

  always_ff @(posedge clk) begin
    ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters with 1-cycle registered lookup
// and write-first bypass. Define BHT_GSHARE_EN to XOR a global history into the index.
module bht_sat_predictor
  import bht_pkg::*;
#(
  parameter int               INDEX_W   = BHT_INDEX_W,
  parameter int               CTR_W     = BHT_CTR_W,
  parameter logic [CTR_W-1:0] RESET_CTR = {CTR_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [CTR_W-1:0]   pred_ctr,
  output logic [INDEX_W-1:0] pred_ghr,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic [INDEX_W-1:0] upd_ghr
);

  localparam int               DEPTH   = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic [INDEX_W-1:0] lkp_idx_s;
  logic [INDEX_W-1:0] upd_idx_s;
  logic [INDEX_W-1:0] ghr_s;

`ifdef BHT_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q;
  logic [INDEX_W-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) begin
      ghr_d = {ghr_q[INDEX_W-2:0], upd_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q <= {INDEX_W{1'b0}};
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Update uses the history captured at lookup, not the current one.
  assign ghr_s     = ghr_q;
  assign lkp_idx_s = lookup_pc ^ ghr_q;
  assign upd_idx_s = upd_pc ^ upd_ghr;
`else
  logic unused_ghr_s;

  assign unused_ghr_s = ^upd_ghr;
  assign ghr_s        = {INDEX_W{1'b0}};
  assign lkp_idx_s    = lookup_pc;
  assign upd_idx_s    = upd_pc;
`endif

  logic [CTR_W-1:0] entry_s [DEPTH];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      logic hit_s;
      assign hit_s = upd_valid & rst & (upd_idx_s == INDEX_W'(g));

      bht_sat_ctr #(
        .CTR_W (CTR_W)
      ) u_ctr (
        .clk        (clk),
        .load_i     (~rst),
        .load_val_i (RESET_CTR),
        .inc_i      (hit_s & upd_taken),
        .dec_i      (hit_s & ~upd_taken),
        .ctr_o      (entry_s[g])
      );
    end
  endgenerate

  logic [CTR_W-1:0] rd_ctr_s;
  logic [CTR_W-1:0] byp_ctr_s;

  // Same-cycle update to the looked-up entry is forwarded (write-first).
  always_comb begin
    rd_ctr_s  = entry_s[lkp_idx_s];
    byp_ctr_s = rd_ctr_s;
    if (upd_valid && (upd_idx_s == lkp_idx_s)) begin
      byp_ctr_s = CTR_W'(sat_update(CTR_W_MAX'(rd_ctr_s), upd_taken, CTR_W_MAX'(CTR_MAX)));
    end else begin
      byp_ctr_s = rd_ctr_s;
    end
  end

  logic               pred_valid_q, pred_valid_d;
  logic               pred_taken_q, pred_taken_d;
  logic [CTR_W-1:0]   pred_ctr_q,   pred_ctr_d;
  logic [INDEX_W-1:0] pred_ghr_q,   pred_ghr_d;

  always_comb begin
    pred_valid_d = lookup_valid;
    pred_taken_d = pred_taken_q;
    pred_ctr_d   = pred_ctr_q;
    pred_ghr_d   = pred_ghr_q;
    if (lookup_valid) begin
      pred_taken_d = byp_ctr_s[CTR_W-1];
      pred_ctr_d   = byp_ctr_s;
      pred_ghr_d   = ghr_s;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_ctr_d   = pred_ctr_q;
      pred_ghr_d   = pred_ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= {CTR_W{1'b0}};
      pred_ghr_q   <= {INDEX_W{1'b0}};
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ctr_q   <= pred_ctr_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_bht_sat_predictor.sv
// Self-checking bench for bht_sat_predictor (default 4 entries x 2-bit counters);
// a reference model pushes expected predictions that a negedge monitor pops.
module tb_bht_sat_predictor;
  import bht_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lookup_valid = 1'b0;
  logic [1:0] lookup_pc = 2'b00;
  logic       pred_valid;
  logic       pred_taken;
  logic [1:0] pred_ctr;
  logic [1:0] pred_ghr;
  logic       upd_valid = 1'b0;
  logic [1:0] upd_pc = 2'b00;
  logic       upd_taken = 1'b0;
  logic [1:0] upd_ghr = 2'b00;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    ctr_t       ctr;
    logic [1:0] ghr;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  ctr_t       model [4];
  logic [1:0] ghr_m = 2'b00;

  bht_sat_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ctr     (pred_ctr),
    .pred_ghr     (pred_ghr),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_ghr      (upd_ghr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ctr_t m_sat(input ctr_t c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // Drive one cycle of stimulus (called at posedge+1), update model, push expectations.
  task automatic drive(input logic lv, input logic [1:0] lpc, input logic uv,
                       input logic [1:0] upc, input logic ut, input logic [1:0] ughr);
    logic [1:0] lidx, uidx;
    ctr_t       rd;
    exp_t       e;
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_ghr = ughr;
    if (rst) begin
`ifdef BHT_GSHARE_EN
      lidx = lpc ^ ghr_m;
      uidx = upc ^ ughr;
`else
      lidx = lpc;
      uidx = upc;
`endif
      rd = model[lidx];
      if (uv && (uidx == lidx)) rd = m_sat(rd, ut);
      if (lv) begin
        e.ctr = rd; e.ghr = ghr_m; e.due = cyc + 1;
        exp_q.push_back(e);
      end
      if (uv) begin
        model[uidx] = m_sat(model[uidx], ut);
`ifdef BHT_GSHARE_EN
        ghr_m = {ghr_m[0], ut};
`endif
      end
    end else begin
      for (int i = 0; i < 4; i++) model[i] = 2'b11;
      ghr_m = 2'b00;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
  endtask

  // Scoreboard consumer: every cycle, either a due prediction or no pred_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          if (pred_valid !== 1'b1) begin
            failures++; $display("FAIL sb_valid: got %b expected 1", pred_valid);
          end
          checks++;
          if (pred_ctr !== e.ctr) begin
            failures++; $display("FAIL sb_ctr: got %b expected %b", pred_ctr, e.ctr);
          end
          checks++;
          if (pred_taken !== e.ctr[1]) begin
            failures++; $display("FAIL sb_taken: got %b expected %b", pred_taken, e.ctr[1]);
          end
          checks++;
          if (pred_ghr !== e.ghr) begin
            failures++; $display("FAIL sb_ghr: got %b expected %b", pred_ghr, e.ghr);
          end
        end else if (pred_valid !== 1'b0) begin
          failures++; $display("FAIL sb_spurious_valid: got %b expected 0", pred_valid);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    idle(); idle();
    checks++;
    if ({pred_valid, pred_taken, pred_ctr, pred_ghr} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {pred_valid, pred_taken, pred_ctr, pred_ghr});
    end
    mon_en = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 2'b00, 1'b0, 2'b00);
      checks++;
      if (pred_valid !== 1'b1 || pred_ctr !== 2'b11 || pred_taken !== 1'b1) begin
        failures++;
        $display("FAIL reset_entry%0d: got v=%b ctr=%b t=%b expected v=1 ctr=11 t=1",
                 i, pred_valid, pred_ctr, pred_taken);
      end
    end
    idle();
    checks++;
    if (pred_valid !== 1'b0 || pred_ctr !== 2'b11) begin
      failures++;
      $display("FAIL hold_after_lookup: got v=%b ctr=%b expected v=0 ctr=11", pred_valid, pred_ctr);
    end
  endtask

  task automatic test_sat_down();
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b00 || pred_taken !== 1'b0) begin
      failures++; $display("FAIL sat_down: got ctr=%b t=%b expected ctr=00 t=0", pred_ctr, pred_taken);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b00) begin
      failures++; $display("FAIL sat_down_floor: got %b expected 00", pred_ctr);
    end
  endtask

  task automatic test_sat_up();
    for (int i = 0; i < 2; i++) drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b10 || pred_taken !== 1'b1) begin
      failures++; $display("FAIL sat_up: got ctr=%b t=%b expected ctr=10 t=1", pred_ctr, pred_taken);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b11) begin
      failures++; $display("FAIL sat_up_ceiling: got %b expected 11", pred_ctr);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b10) begin
      failures++; $display("FAIL bypass_same_idx: got %b expected 10", pred_ctr);
    end
    drive(1'b1, 2'b11, 1'b1, 2'b10, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b11) begin
      failures++; $display("FAIL bypass_other_idx: got %b expected 11", pred_ctr);
    end
    drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b01) begin
      failures++; $display("FAIL bypass_written: got %b expected 01", pred_ctr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
            2'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)));
    end
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00);
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00);
    rst = 1'b0;
    drive(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_valid !== 1'b0 || pred_ctr !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_drop: got v=%b ctr=%b expected v=0 ctr=00", pred_valid, pred_ctr);
    end
    rst = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_valid !== 1'b1 || pred_ctr !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid_restore: got v=%b ctr=%b expected v=1 ctr=11", pred_valid, pred_ctr);
    end
    idle();
  endtask

  task automatic test_ghr();
    rst = 1'b0;
    idle();
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00);
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
`ifdef BHT_GSHARE_EN
    checks++;
    if (pred_ghr !== 2'b11 || pred_ctr !== 2'b11) begin
      failures++; $display("FAIL gshare_lookup: got ghr=%b ctr=%b expected ghr=11 ctr=11", pred_ghr, pred_ctr);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b11);
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b10 || pred_ghr !== 2'b10) begin
      failures++; $display("FAIL gshare_update: got ctr=%b ghr=%b expected ctr=10 ghr=10", pred_ctr, pred_ghr);
    end
`else
    checks++;
    if (pred_ghr !== 2'b00 || pred_ctr !== 2'b11) begin
      failures++; $display("FAIL ghr_default: got ghr=%b ctr=%b expected ghr=00 ctr=11", pred_ghr, pred_ctr);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b11);
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
    checks++;
    if (pred_ctr !== 2'b10 || pred_ghr !== 2'b00) begin
      failures++; $display("FAIL upd_ghr_ignored: got ctr=%b ghr=%b expected ctr=10 ghr=00", pred_ctr, pred_ghr);
    end
`endif
    idle();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_sat_down();
    test_sat_up();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_ghr();
    idle(); idle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
